// File: rtl/chess_board_mapper_if.sv
// Pixel/board bus between the VGA scan source and chess_board_mapper.
// master drives scan position and board writes; slave returns per-pixel square data.
interface chess_board_mapper_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        wr_en;
    logic [5:0]  wr_square;
    logic [3:0]  wr_piece;
    logic [5:0]  cursor_sq;
    logic [3:0]  piece_q;
    logic [11:0] rom_address;
    logic        light_sq;
    logic        in_board;
    logic        blank_q;
    logic        cursor_hit;

    modport master (
        output DrawX, DrawY, blank, wr_en, wr_square, wr_piece, cursor_sq,
        input  piece_q, rom_address, light_sq, in_board, blank_q, cursor_hit
    );

    modport slave (
        input  DrawX, DrawY, blank, wr_en, wr_square, wr_piece, cursor_sq,
        output piece_q, rom_address, light_sq, in_board, blank_q, cursor_hit
    );
endinterface

// File: rtl/chess_board_mapper.sv
// Two-stage pixel-to-square mapper with an internal 64-entry board register file.
// Optional feature: define CURSOR_EN to enable cursor_hit; otherwise it is tied to 0.
module chess_board_mapper #(
    parameter int X_OFFSET = 80,
    parameter int SQ_SIZE  = 60
) (
    input  logic                  i_vga_clk,
    input  logic                  i_reset,
    chess_board_mapper_if.slave   bus
);
    localparam logic [9:0] X_LO   = 10'(X_OFFSET);
    localparam logic [9:0] X_HI   = 10'(X_OFFSET + 8*SQ_SIZE);
    localparam logic [9:0] Y_HI   = 10'(8*SQ_SIZE);
    localparam logic [9:0] SQ_10  = 10'(SQ_SIZE);
    localparam logic [11:0] SQ_12 = 12'(SQ_SIZE);

    // Quotient by threshold compare; operands never exceed 8*SQ_SIZE here.
    function automatic logic [2:0] sq_div(input logic [9:0] v);
        sq_div = '0;
        for (int i = 1; i < 8; i++) begin
            if (v >= 10'(i*SQ_SIZE)) sq_div = 3'(i);
        end
    endfunction

    function automatic logic [3:0] start_piece(input logic [5:0] sq);
        logic [3:0] back;
        case (sq[2:0])
            3'd0, 3'd7: back = 4'd4;
            3'd1, 3'd6: back = 4'd2;
            3'd2, 3'd5: back = 4'd3;
            3'd3:       back = 4'd5;
            default:    back = 4'd6;
        endcase
        case (sq[5:3])
            3'd0:    start_piece = back + 4'd8;
            3'd1:    start_piece = 4'd9;
            3'd6:    start_piece = 4'd1;
            3'd7:    start_piece = back;
            default: start_piece = 4'd0;
        endcase
    endfunction

    logic [9:0] w_x_rel;
    logic       w_in_board;
    logic [2:0] w_col;
    logic [2:0] w_row;
    logic [5:0] w_sx;
    logic [5:0] w_sy;

    always_comb begin
        w_x_rel    = bus.DrawX - X_LO;
        w_in_board = (bus.DrawX >= X_LO) && (bus.DrawX < X_HI) && (bus.DrawY < Y_HI);
        w_col      = '0;
        w_row      = '0;
        w_sx       = '0;
        w_sy       = '0;
        if (w_in_board) begin
            w_col = sq_div(w_x_rel);
            w_row = sq_div(bus.DrawY);
            w_sx  = 6'(w_x_rel   - {7'd0, w_col} * SQ_10);
            w_sy  = 6'(bus.DrawY - {7'd0, w_row} * SQ_10);
        end
    end

    logic       r_s1_in;
    logic [2:0] r_s1_col;
    logic [2:0] r_s1_row;
    logic [5:0] r_s1_sx;
    logic [5:0] r_s1_sy;
    logic       r_s1_blank;
    logic       r_flush;

    // Stage 1 stays empty for one extra cycle after reset so the outputs read 0
    // for the reset cycle plus two refill cycles.
    always_ff @(posedge i_vga_clk) begin
        r_flush <= i_reset;
        if (i_reset || r_flush) begin
            r_s1_in    <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_sx    <= '0;
            r_s1_sy    <= '0;
            r_s1_blank <= 1'b0;
        end else begin
            r_s1_in    <= w_in_board;
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
            r_s1_sx    <= w_sx;
            r_s1_sy    <= w_sy;
            r_s1_blank <= bus.blank;
        end
    end

    logic [3:0] r_board [64];

    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 64; i++) r_board[i] <= start_piece(6'(i));
        end else if (bus.wr_en) begin
            r_board[bus.wr_square] <= bus.wr_piece;
        end
    end

    logic [5:0]  w_rd_sq;
    logic [3:0]  w_rd_piece;
    logic [11:0] w_rom;
    logic        w_cursor;

    always_comb begin
        w_rd_sq    = {r_s1_row, r_s1_col};
        w_rd_piece = (bus.wr_en && (bus.wr_square == w_rd_sq)) ? bus.wr_piece : r_board[w_rd_sq];
        w_rom      = 12'(r_s1_sy) * SQ_12 + 12'(r_s1_sx);
`ifdef CURSOR_EN
        w_cursor   = r_s1_in && (w_rd_sq == bus.cursor_sq);
`else
        w_cursor   = 1'b0;
`endif
    end

    logic [3:0]  r_piece_q;
    logic [11:0] r_rom_address;
    logic        r_light_sq;
    logic        r_in_board;
    logic        r_blank_q;
    logic        r_cursor_hit;

    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            r_piece_q     <= '0;
            r_rom_address <= '0;
            r_light_sq    <= 1'b0;
            r_in_board    <= 1'b0;
            r_blank_q     <= 1'b0;
            r_cursor_hit  <= 1'b0;
        end else begin
            r_piece_q     <= r_s1_in ? w_rd_piece : 4'd0;
            r_rom_address <= w_rom;
            r_light_sq    <= r_s1_in & ~(r_s1_row[0] ^ r_s1_col[0]);
            r_in_board    <= r_s1_in;
            r_blank_q     <= r_s1_blank;
            r_cursor_hit  <= w_cursor;
        end
    end

    assign bus.piece_q     = r_piece_q;
    assign bus.rom_address = r_rom_address;
    assign bus.light_sq    = r_light_sq;
    assign bus.in_board    = r_in_board;
    assign bus.blank_q     = r_blank_q;
    assign bus.cursor_hit  = r_cursor_hit;
endmodule

// File: doc/chess_board_mapper.md
# chess_board_mapper

Pixel-to-board mapping stage sitting directly upstream of the per-piece sprite ROM/palette stages. It takes the VGA scan position, determines which of the 64 board squares the pixel falls in, and reads that square's piece code from an internal board register file. It also produces the 60x60 sprite ROM address local to the square. All outputs are pipeline-aligned so the downstream sprite and palette stage can select a piece ROM and colour the pixel without recomputing coordinates.

## Interface
- X_OFFSET, 80: left edge of the board in screen pixels.
- SQ_SIZE, 60: square edge in pixels; equals the sprite dimension.
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current scan column, 0..799.
- DrawY  in  10  current scan row, 0..524.
- blank  in  1  1 = visible pixel (active video).
- wr_en  in  1  board write strobe.
- wr_square  in  6  square index written, row*8+col.
- wr_piece  in  4  piece code written.
- cursor_sq  in  6  highlighted square; used only with CURSOR_EN.
- piece_q  out  4  piece code at the pixel's square; 0 outside the board.
- rom_address  out  12  sy*SQ_SIZE+sx, range 0..3599; 0 outside the board.
- light_sq  out  1  1 when (row+col) is even.
- in_board  out  1  pixel lies inside the 480x480 board.
- blank_q  out  1  blank delayed to align with the other outputs.
- cursor_hit  out  1  pixel's square equals cursor_sq.

## Operation
- Clock and reset: one clock (vga_clk); reset is synchronous and active-high.
- Piece codes:
  - 0: empty.
  - 1..6: white P N B R Q K.
  - 9..14: black P N B R Q K.
  - 7, 8, 15: reserved; stored and returned as written.
- Board geometry:
  - Row 0 is the top of the screen (rank 8). Column 0 is the left edge (file a).
  - Square index = row*8+col.
- Stage 1 (registered):
  - in_board when X_OFFSET ≤ DrawX < X_OFFSET+8*SQ_SIZE and DrawY < 8*SQ_SIZE.
  - col = (DrawX−X_OFFSET)/SQ_SIZE; sx = remainder.
  - row = DrawY/SQ_SIZE; sy = remainder.
  - Arithmetic is unsigned, 10 bits. Outside the board, col/row/sx/sy are forced to 0.
  - blank is registered here.
- Stage 2 (registered):
  - piece_q = board[row*8+col], gated to 0 when !in_board.
  - rom_address = sy*SQ_SIZE+sx, computed in 12 bits.
  - light_sq, cursor_hit, in_board and blank_q are registered here.
- Board write: when wr_en, board[wr_square] ← wr_piece at the clock edge.
- Write/read collision: if the stage-2 read and a write target the same square in the same cycle, piece_q returns wr_piece (write-first).
- Reset:
  - All outputs go to 0 and the pipeline is cleared.
  - The board is loaded in one cycle with the standard start position:
    - Squares 0..7 = 12,10,11,13,14,11,10,12.
    - Squares 8..15 = 9.
    - Squares 16..47 = 0.
    - Squares 48..55 = 1.
    - Squares 56..63 = 4,2,3,5,6,3,2,4.
  - A write asserted in the reset cycle is ignored.

## Timing
- Latency is 2 cycles, from DrawX/DrawY/blank to every output. There is no stall; one pixel is accepted per cycle.
- A write is visible to a stage-2 read in the same cycle (see collision rule). The write persists from the next cycle onward.
- Reset mid-frame: the outputs read 0 for the reset cycle plus 2 cycles while the pipeline refills. Scanning then resumes with the start position, regardless of earlier writes.
- Boundary pixels:
  - DrawX = X_OFFSET−1 → in_board = 0.
  - DrawX = X_OFFSET → col 0, sx 0.
  - DrawX = X_OFFSET+479 → col 7, sx 59.
  - DrawY = 479 → row 7, sy 59.
  - DrawY = 480 → in_board = 0.
- Outputs are computed even when blank = 0; the consumer gates on blank_q.

## Configuration
- CURSOR_EN defined:
  - cursor_hit = in_board && (row*8+col == cursor_sq), aligned with the other outputs.
- CURSOR_EN undefined:
  - cursor_hit is constant 0 and cursor_sq is ignored.
  - The port list is unchanged.

## Test plan
- Reset, then scan (DrawX=80, DrawY=0) → 2 cycles later: piece_q=12, rom_address=0, light_sq=1, in_board=1.
- Scan (DrawX=559, DrawY=479) → piece_q=4, rom_address=3599, light_sq=1. Scan (DrawX=560, DrawY=0) → in_board=0, piece_q=0, rom_address=0.
- Write square 36 = 6, then scan (DrawX=320, DrawY=250) → piece_q=6, rom_address=10*60+0=600, light_sq=1.
- Collision: write square 0 = 5 in the same cycle that stage 2 reads square 0 → piece_q=5 that cycle.
- Write square 20 = 3; pulse reset mid-line; rescan square 20 → piece_q=0. Outputs stay 0 for 3 cycles after reset asserts.
- CURSOR_EN with cursor_sq=63: scan (DrawX=500, DrawY=450) → cursor_hit=1. Scan (DrawX=440, DrawY=450) → cursor_hit=0. Without CURSOR_EN, cursor_hit=0 for both.
